// File: rtl/vend_controller_n.sv
// vend_controller_n: multi-item vending controller with per-item stock,
// coin credit accumulation, cancel/refund and greedy 25/10/5 change return.
// Optional audit counters (sales_count, revenue) enabled by VEND_AUDIT_EN.
module vend_controller_n #(
   parameter int NUM_ITEMS  = 4,
   parameter int PRICE_W    = 8,
   parameter int STOCK_W    = 4,
   parameter int STOCK_INIT = 5,
   localparam int IDX_W     = $clog2(NUM_ITEMS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         coin_5,
   input  logic                         coin_10,
   input  logic                         coin_25,
   input  logic                         next_item,
   input  logic                         select,
   input  logic                         cancel,
   input  logic                         restock,
   input  logic [NUM_ITEMS*PRICE_W-1:0] price_table,
   output logic [IDX_W-1:0]             selected_item,
   output logic [PRICE_W-1:0]           credit,
   output logic                         dispense,
   output logic [IDX_W-1:0]             dispensed_item,
   output logic                         coin_out_5,
   output logic                         coin_out_10,
   output logic                         coin_out_25,
   output logic                         coin_reject,
   output logic                         sold_out,
   output logic                         busy
`ifdef VEND_AUDIT_EN
   ,
   output logic [15:0]                  sales_count,
   output logic [23:0]                  revenue
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_COLL = 2'd1;
   localparam logic [1:0] S_VEND = 2'd2;
   localparam logic [1:0] S_CHG  = 2'd3;

   localparam logic [PRICE_W:0]   V5  = (PRICE_W+1)'(5);
   localparam logic [PRICE_W:0]   V10 = (PRICE_W+1)'(10);
   localparam logic [PRICE_W:0]   V25 = (PRICE_W+1)'(25);
   localparam logic [PRICE_W-1:0] C5  = PRICE_W'(5);
   localparam logic [PRICE_W-1:0] C10 = PRICE_W'(10);
   localparam logic [PRICE_W-1:0] C25 = PRICE_W'(25);

   logic [1:0]         state_q, state_d;
   logic [PRICE_W-1:0] credit_q, credit_d;
   logic [IDX_W-1:0]   sel_q, sel_d;
   logic               ni_q, ni_d;
   logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
   logic [STOCK_W-1:0] stock_d [NUM_ITEMS];
   logic               dispense_q, dispense_d;
   logic [IDX_W-1:0]   disp_item_q, disp_item_d;
   logic               out5_q, out5_d, out10_q, out10_d, out25_q, out25_d;
   logic               reject_q, reject_d;
   logic               sold_q, sold_d;
   logic               busy_q, busy_d;
`ifdef VEND_AUDIT_EN
   logic [15:0]        sales_q, sales_d;
   logic [23:0]        revenue_q, revenue_d;
`endif

   logic [PRICE_W:0]   coin_sum, credit_sum;
   logic [PRICE_W-1:0] credit_acc, chg_src, price_sel;
   logic               any_coin, ni_rise, chg_req;

   assign price_sel  = price_table[sel_q*PRICE_W +: PRICE_W];
   assign any_coin   = coin_5 | coin_10 | coin_25;
   assign coin_sum   = (coin_5 ? V5 : '0) + (coin_10 ? V10 : '0) + (coin_25 ? V25 : '0);
   assign credit_sum = {1'b0, credit_q} + coin_sum;
   assign ni_rise    = next_item & ~ni_q;

   // Next-state logic: coin intake, selection, purchase, and one change coin per cycle.
   // A change coin is chosen on the edge that enters (or stays in) CHANGE, so each
   // CHANGE cycle shows exactly the coin being ejected in that cycle.
   always_comb begin
      state_d     = state_q;
      credit_d    = credit_q;
      sel_d       = sel_q;
      ni_d        = next_item;
      stock_d     = stock_q;
      dispense_d  = 1'b0;
      disp_item_d = disp_item_q;
      out5_d      = 1'b0;
      out10_d     = 1'b0;
      out25_d     = 1'b0;
      reject_d    = 1'b0;
      sold_d      = 1'b0;
      chg_req     = 1'b0;
      chg_src     = credit_q;
      credit_acc  = credit_q;
`ifdef VEND_AUDIT_EN
      sales_d     = sales_q;
      revenue_d   = revenue_q;
`endif
      case (state_q)
         S_IDLE, S_COLL: begin
            if (any_coin) begin
               if (credit_sum[PRICE_W]) begin
                  reject_d = 1'b1;
               end else begin
                  credit_acc = credit_sum[PRICE_W-1:0];
                  state_d    = S_COLL;
               end
            end
            credit_d = credit_acc;
            if (ni_rise)
               sel_d = (sel_q == IDX_W'(NUM_ITEMS-1)) ? '0 : sel_q + 1'b1;
            if (state_q == S_IDLE && restock) begin
               for (int i = 0; i < NUM_ITEMS; i++) stock_d[i] = STOCK_W'(STOCK_INIT);
            end
            if (state_q == S_COLL) begin
               if (cancel) begin
                  chg_req = 1'b1;
                  chg_src = credit_acc;
               end else if (select) begin
                  if (stock_q[sel_q] == '0) begin
                     sold_d = 1'b1;
                  end else if (credit_q >= price_sel) begin
                     state_d        = S_VEND;
                     credit_d       = credit_acc - price_sel;
                     stock_d[sel_q] = stock_q[sel_q] - 1'b1;
                     dispense_d     = 1'b1;
                     disp_item_d    = sel_q;
`ifdef VEND_AUDIT_EN
                     sales_d   = (sales_q == 16'hFFFF) ? sales_q : sales_q + 16'd1;
                     revenue_d = revenue_q + 24'(price_sel);
`endif
                  end
               end
            end
         end
         default: begin
            // VEND and CHANGE: coins refused, change continues from current credit
            reject_d = any_coin;
            chg_req  = 1'b1;
            chg_src  = credit_q;
         end
      endcase
      if (chg_req) begin
         state_d = S_CHG;
         if (chg_src >= C25) begin
            out25_d  = 1'b1;
            credit_d = chg_src - C25;
         end else if (chg_src >= C10) begin
            out10_d  = 1'b1;
            credit_d = chg_src - C10;
         end else if (chg_src >= C5) begin
            out5_d   = 1'b1;
            credit_d = chg_src - C5;
         end else begin
            // nothing left to return; sub-5 residue is forfeited
            state_d  = S_IDLE;
            credit_d = '0;
         end
      end
      busy_d = (state_d == S_VEND) || (state_d == S_CHG);
   end

   // State and registered outputs, synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         credit_q    <= '0;
         sel_q       <= '0;
         ni_q        <= 1'b0;
         for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
         dispense_q  <= 1'b0;
         disp_item_q <= '0;
         out5_q      <= 1'b0;
         out10_q     <= 1'b0;
         out25_q     <= 1'b0;
         reject_q    <= 1'b0;
         sold_q      <= 1'b0;
         busy_q      <= 1'b0;
`ifdef VEND_AUDIT_EN
         sales_q     <= '0;
         revenue_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         credit_q    <= credit_d;
         sel_q       <= sel_d;
         ni_q        <= ni_d;
         stock_q     <= stock_d;
         dispense_q  <= dispense_d;
         disp_item_q <= disp_item_d;
         out5_q      <= out5_d;
         out10_q     <= out10_d;
         out25_q     <= out25_d;
         reject_q    <= reject_d;
         sold_q      <= sold_d;
         busy_q      <= busy_d;
`ifdef VEND_AUDIT_EN
         sales_q     <= sales_d;
         revenue_q   <= revenue_d;
`endif
      end
   end

   assign selected_item  = sel_q;
   assign credit         = credit_q;
   assign dispense       = dispense_q;
   assign dispensed_item = disp_item_q;
   assign coin_out_5     = out5_q;
   assign coin_out_10    = out10_q;
   assign coin_out_25    = out25_q;
   assign coin_reject    = reject_q;
   assign sold_out       = sold_q;
   assign busy           = busy_q;
`ifdef VEND_AUDIT_EN
   assign sales_count    = sales_q;
   assign revenue        = revenue_q;
`endif

endmodule

// File: doc/vend_controller_n.md
Name: vend_controller_n

Overview:
Parametrised successor to the single-product-table vending FSM. Supports NUM_ITEMS products with run-time prices and per-item stock counters. Accumulates coin credit and handles cancel/refund. Returns change as a timed sequence of individual coin-eject pulses using greedy 25/10/5 selection. Sits between the front-panel coin/button inputs and the dispense and coin-return actuators.

Parameters:
NUM_ITEMS, 4, number of products (>=2); selector width IDX_W = $clog2(NUM_ITEMS)
PRICE_W, 8, width of prices, credit and change arithmetic
STOCK_W, 4, width of each per-item stock counter
STOCK_INIT, 5, stock loaded into every item on reset or restock (must be < 2**STOCK_W)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
coin_5 / coin_10 / coin_25  in  1 each  one-cycle coin-accepted pulses
next_item  in  1  level button; internal rising-edge detect advances selection
select  in  1  purchase request, sampled each cycle
cancel  in  1  abort transaction and refund all credit
restock  in  1  pulse; reload all stock counters to STOCK_INIT
price_table  in  NUM_ITEMS*PRICE_W  price of item i at bits [i*PRICE_W +: PRICE_W]
selected_item  out  IDX_W  current selection
credit  out  PRICE_W  current accumulated credit
dispense  out  1  one-cycle vend pulse
dispensed_item  out  IDX_W  item index, valid while dispense=1
coin_out_5 / coin_out_10 / coin_out_25  out  1 each  one-cycle eject pulses, at most one high per cycle
coin_reject  out  1  one-cycle pulse when a coin is refused
sold_out  out  1  one-cycle pulse when select targets an item with zero stock
busy  out  1  high in VEND and CHANGE states

Behaviour:
- Reset, synchronous:
  - state=IDLE, credit=0, selected_item=0.
  - All stock = STOCK_INIT.
  - All pulse outputs = 0, busy=0, dispensed_item=0.
- FSM states: IDLE, COLLECTING, VEND, CHANGE. All outputs are registered.
- Coins in IDLE or COLLECTING:
  - Sum of all coins asserted in a cycle is added to credit on that edge.
  - IDLE moves to COLLECTING on any accepted coin.
  - If credit + sum > 2**PRICE_W-1, all coins that cycle are rejected: credit unchanged, coin_reject=1 next cycle.
- Coins in VEND or CHANGE are rejected (coin_reject pulse).
- next_item:
  - Advances selection on its rising edge, in IDLE and COLLECTING only.
  - Wraps from NUM_ITEMS-1 to 0.
  - Ignored while busy; the edge detector still tracks the input.
- select in COLLECTING:
  - If stock[sel]==0: sold_out pulse, stay in COLLECTING.
  - Else if credit < price[sel]: ignored.
  - Else: go to VEND; credit -= price[sel]; stock[sel] -= 1.
- select in IDLE is ignored.
- cancel in COLLECTING goes to CHANGE with credit unchanged. cancel wins over a simultaneous select. cancel is ignored elsewhere.
- VEND (exactly one cycle):
  - dispense=1 and dispensed_item=sel during the cycle after select was sampled.
  - Next state is CHANGE if credit >= 5, else IDLE with credit forced to 0.
- CHANGE: one coin per cycle, greedy order.
  - If credit >= 25: coin_out_25, credit -= 25.
  - Else if >= 10: coin_out_10, credit -= 10.
  - Else if >= 5: coin_out_5, credit -= 5.
  - When credit < 5 after an eject, next state is IDLE and credit is cleared. Sub-5 residue is forfeited; prices are specified as multiples of 5.
- restock:
  - Honoured in IDLE only; ignored otherwise.
  - restock and select in the same cycle is impossible, since select is only acted on in COLLECTING.
- Stock counters never underflow.
- Reset mid-VEND or mid-CHANGE aborts: no further ejects, credit lost.

Optional Feature:
VEND_AUDIT_EN
- Defined:
  - Adds output sales_count (16 bits): +1 per dispense, saturating at 16'hFFFF.
  - Adds output revenue (24 bits): += price on each dispense, wraps modulo 2**24.
  - Both clear on reset only.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Prices {25,50,100,200}; next_item once (sel=1); coins 25,25,10; select.
  -> dispense with dispensed_item=1 one cycle after select; next cycle coin_out_10; then IDLE with credit=0; stock[1]=STOCK_INIT-1.
- Coins 25,10,5 (credit=40); cancel.
  -> coin_out_25, coin_out_10, coin_out_5 on three consecutive cycles; no dispense; IDLE; credit=0.
- Buy item 0 five times with STOCK_INIT=5; sixth attempt with credit 25.
  -> sold_out pulse, no dispense, credit stays 25; restock later in IDLE makes item 0 purchasable again.
- PRICE_W=8, credit=250; coin_10.
  -> coin_reject pulse, credit stays 250; coin_5 next cycle -> credit=255.
- next_item pressed 5 times with NUM_ITEMS=4.
  -> selection 1,2,3,0,1. Holding next_item high for 10 cycles advances only once. Presses during CHANGE are ignored.
- Coins 25 and 10 in the same cycle, then select on item 0 (price 25), then reset on the first CHANGE cycle.
  -> credit=35; dispense; first CHANGE cycle ejects coin_out_10; reset cycle gives all outputs 0, credit 0, state IDLE.
